line_buffer_feeder: RTL

- Producer-side sequencer that drives the `line_buffer` pixel port.
- Accepts an unpadded raster pixel stream over a valid/ready handshake and emits exactly one channel sample per beat, in row, column, channel order.
- Inserts `PADDING` all-zero rows above and below the image, raising `pad_top` / `pad_bottom` on those beats, so the line buffer sees a correctly padded frame.
- Sits between the frame source (DMA/frame memory reader) and `line_buffer` in the CNN front end.

---
 rtl/line_buffer_feeder_if.sv | 45 ++++
 rtl/line_buffer_feeder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/line_buffer_feeder_if.sv
// rtl/line_buffer_feeder_if.sv - pixel-path bundle between frame source, feeder and line_buffer
//
// Signals:
//   s_pixel, s_valid, s_ready   upstream raster samples (valid/ready)
//   lb_stall                    line buffer cannot take a beat this cycle
//   pixel_out, pixel_valid      beat presented to line_buffer pixel_in
//   pad_top, pad_bottom         beat belongs to a top / bottom pad row
//   row_idx, col_idx, ch_idx    padded position of the beat on pixel_out
// Modports: master = feeder side, slave = source/line-buffer side.
interface line_buffer_feeder_if #(
  parameter int IN_CHANNELS  = 4,
  parameter int IMAGE_WIDTH  = 16,
  parameter int IMAGE_HEIGHT = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int PADDING      = 1
);
  localparam int ROWS = IMAGE_HEIGHT + 2 * PADDING;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COLW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int CW   = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;

  logic signed [DATA_WIDTH-1:0] s_pixel;
  logic                         s_valid;
  logic                         s_ready;
  logic                         lb_stall;
  logic signed [DATA_WIDTH-1:0] pixel_out;
  logic                         pixel_valid;
  logic                         pad_top;
  logic                         pad_bottom;
  logic [RW-1:0]                row_idx;
  logic [COLW-1:0]              col_idx;
  logic [CW-1:0]                ch_idx;

  modport master (
    input  s_pixel, s_valid, lb_stall,
    output s_ready, pixel_out, pixel_valid, pad_top, pad_bottom,
           row_idx, col_idx, ch_idx
  );

  modport slave (
    output s_pixel, s_valid, lb_stall,
    input  s_ready, pixel_out, pixel_valid, pad_top, pad_bottom,
           row_idx, col_idx, ch_idx
  );
endinterface

// File: rtl/line_buffer_feeder.sv
// rtl/line_buffer_feeder.sv - padded raster sequencer driving the line_buffer pixel port
//
// Optional feature macro: LB_FEEDER_FRAME_CNT_EN (adds 16-bit frame_count output).
// Ports:
//   clk           single rising-edge clock
//   rst           asynchronous active-low reset
//   start         one-cycle frame start, ignored while busy
//   bus (master)  upstream samples in, padded beats with flags and indices out
//   busy          high from the cycle after an accepted start to the end of DONE
//   frame_done    one-cycle pulse after the last beat of a frame
//   frame_count   completed frames, wrapping (only with LB_FEEDER_FRAME_CNT_EN)
module line_buffer_feeder #(
  parameter int IN_CHANNELS  = 4,
  parameter int IMAGE_WIDTH  = 16,
  parameter int IMAGE_HEIGHT = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int PADDING      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  line_buffer_feeder_if.master bus,
  output logic                 busy,
  output logic                 frame_done
`ifdef LB_FEEDER_FRAME_CNT_EN
  ,
  output logic [15:0]          frame_count
`endif
);
  localparam int ROWS = IMAGE_HEIGHT + 2 * PADDING;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COLW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int CW   = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;

  localparam logic [CW-1:0]   CH_LAST     = CW'(IN_CHANNELS - 1);
  localparam logic [COLW-1:0] COL_LAST    = COLW'(IMAGE_WIDTH - 1);
  // Last padded row of each phase; TOP_LAST is unused when PADDING==0.
  localparam logic [RW-1:0]   TOP_LAST    = RW'(PADDING - 1);
  localparam logic [RW-1:0]   STREAM_LAST = RW'(PADDING + IMAGE_HEIGHT - 1);
  localparam logic [RW-1:0]   BOT_LAST    = RW'(ROWS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAD_TOP,
    ST_STREAM,
    ST_PAD_BOTTOM,
    ST_DONE
  } state_t;

  state_t state;

  // Position of the next beat to be emitted (row counts padded rows).
  logic [CW-1:0]   ch;
  logic [COLW-1:0] col;
  logic [RW-1:0]   row;

  // Registered view of the beat currently on pixel_out.
  logic signed [DATA_WIDTH-1:0] pixel_q;
  logic                         valid_q;
  logic                         top_q;
  logic                         bot_q;
  logic [RW-1:0]                row_q;
  logic [COLW-1:0]              col_q;
  logic [CW-1:0]                ch_q;

  logic                         s_ready_c;
  logic                         emit;
  logic                         row_end;
  logic signed [DATA_WIDTH-1:0] beat_data;

  always_comb begin
    s_ready_c = (state == ST_STREAM) && !bus.lb_stall;
    emit      = 1'b0;
    case (state)
      ST_PAD_TOP, ST_PAD_BOTTOM: emit = !bus.lb_stall;
      ST_STREAM:                 emit = bus.s_valid && s_ready_c;
      default:                   emit = 1'b0;
    endcase
    beat_data = (state == ST_STREAM) ? bus.s_pixel : '0;
    row_end   = (ch == CH_LAST) && (col == COL_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      ch         <= '0;
      col        <= '0;
      row        <= '0;
      pixel_q    <= '0;
      valid_q    <= 1'b0;
      top_q      <= 1'b0;
      bot_q      <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      ch_q       <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_q    <= emit;
      frame_done <= 1'b0;

      // Outputs and indices change only with a real beat; bubbles hold them.
      if (emit) begin
        pixel_q <= beat_data;
        top_q   <= (state == ST_PAD_TOP);
        bot_q   <= (state == ST_PAD_BOTTOM);
        row_q   <= row;
        col_q   <= col;
        ch_q    <= ch;
        if (ch == CH_LAST) begin
          ch <= '0;
          if (col == COL_LAST) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end else begin
          ch <= ch + 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            ch    <= '0;
            col   <= '0;
            row   <= '0;
            busy  <= 1'b1;
            state <= (PADDING > 0) ? ST_PAD_TOP : ST_STREAM;
          end
        end
        ST_PAD_TOP: begin
          if (emit && row_end && (row == TOP_LAST)) state <= ST_STREAM;
        end
        ST_STREAM: begin
          if (emit && row_end && (row == STREAM_LAST))
            state <= (PADDING > 0) ? ST_PAD_BOTTOM : ST_DONE;
        end
        ST_PAD_BOTTOM: begin
          if (emit && row_end && (row == BOT_LAST)) state <= ST_DONE;
        end
        ST_DONE: begin
          // The DONE cycle still counts as busy, so a start seen here is dropped.
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef LB_FEEDER_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_count <= '0;
    end else if (state == ST_DONE) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

  assign bus.s_ready     = s_ready_c;
  assign bus.pixel_out   = pixel_q;
  assign bus.pixel_valid = valid_q;
  assign bus.pad_top     = top_q;
  assign bus.pad_bottom  = bot_q;
  assign bus.row_idx     = row_q;
  assign bus.col_idx     = col_q;
  assign bus.ch_idx      = ch_q;
endmodule
